result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 16: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: result-buffer entries; must be a power of two, 2..16.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  8  result byte from the XOR/shift stage.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 tx  output  1  serial line; idles high.
REQ-009 busy  output  1  high while a frame is on the line.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-011 Push: in_valid && in_ready at a rising edge writes in_data into the FIFO; fifo_count increments on that edge.
REQ-012 in_ready = (fifo_count != FIFO_DEPTH); it is a combinational function of registered count only, with no dependence on a same-cycle pop.
REQ-013 The FSM has five states: IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE with fifo_count != 0: the block pops the head into the shift register and enters START on the same edge; busy rises on that edge.
REQ-015 A simultaneous push and pop leaves fifo_count unchanged.
REQ-016 IDLE with an empty FIFO: the FSM stays in IDLE, tx=1, busy=0.
REQ-017 Each of START, each data bit, PARITY and STOP drives tx for exactly CLK_DIV cycles, timed by a baud counter that reloads on every state or bit change.
REQ-018 Line levels: START drives tx=0; DATA sends 8 bits LSB first; STOP drives tx=1.
REQ-019 After STOP the FSM returns to IDLE. If the FIFO is non-empty it enters START on the next edge, so back-to-back frames have exactly one idle cycle between stop and start.
REQ-020 tx and busy are registered outputs.
REQ-021 in_data is sampled only at push; later changes to in_data do not affect buffered bytes.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 Pushes while full are ignored (in_ready=0); no overwrite occurs.

Reset
REQ-024 While rst_n=0 at an edge, all of the following apply:
- FSM goes to IDLE;
- FIFO pointers and fifo_count clear to 0;
- baud counter and shift register clear to 0;
- tx=1, busy=0.
REQ-025 Reset mid-frame aborts the frame: tx is 1 from the first edge with rst_n=0, and buffered bytes are discarded.
REQ-026 in_ready=1 during and after reset.

Configuration
REQ-027 Macro RESULT_UART_TX_PARITY_EN controls the PARITY state.
- Defined: the PARITY state is present and transmits the even-parity bit (XOR of the 8 data bits) between DATA and STOP.
- Undefined: DATA transitions directly to STOP, and no parity logic is synthesized.

Structure
REQ-028 A shared package result_uart_pkg holds:
- the FSM state enum (tx_state_t);
- the line-level constants TX_IDLE_LVL=1, TX_START_LVL=0, TX_STOP_LVL=1.
REQ-029 The FIFO is a separate sub-module result_fifo, parameterised by FIFO_DEPTH and width 8, exposing push, pop, full, empty and count.
REQ-030 The FSM, baud counter and shift register live in result_uart_tx.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-031 Push 0xA5 with parity enabled -> line sequence, each level held 4 cycles: tx=0 (start); 1,0,1,0,0,1,0,1 (data); 0 (parity); 1 (stop). busy is high for 44 cycles.
REQ-032 Push 0xA5 with parity disabled -> the same frame minus the parity bit; busy is high for 40 cycles.
REQ-033 Hold in_valid=1 with data 0x01..0x06 from idle -> exactly 5 bytes are accepted, in_ready falls in cycle 5, fifo_count=4, and 0x01..0x05 are transmitted in order.
REQ-034 Push two bytes back-to-back -> the second START begins exactly one cycle after the first STOP ends.
REQ-035 Assert rst_n=0 for one cycle during data bit 3 of a frame with 2 bytes buffered -> tx=1 and fifo_count=0 on the next edge, and no further frames are sent.
REQ-036 Hold in_valid=1 while full and an external push of 0xFF is presented -> 0xFF is never transmitted unless it is re-presented after in_ready=1.

Source files
------------

// File: rtl/result_uart_pkg.sv
// Shared types and line-level constants for the result UART transmitter.
// The optional parity stage is selected with RESULT_UART_TX_PARITY_EN.
package result_uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam logic TX_START_LVL = 1'b0;
  localparam logic TX_STOP_LVL  = 1'b1;

endpackage

// File: rtl/result_uart_tx_fifo.sv
// Result buffer: power-of-two FIFO with registered occupancy count.
// A push while full is dropped; a pop while empty is ignored.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c, do_pop_c;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_data  = mem_q[rd_ptr_q];
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;

  // Pointer and count update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/result_uart_tx.sv
// Buffered 8-bit UART transmitter for result bytes (start, 8 data LSB first,
// optional even parity, stop). Parity stage enabled by RESULT_UART_TX_PARITY_EN.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           tx,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int unsigned BAUD_W = 8;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

  tx_state_t          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
`ifdef RESULT_UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic [DATA_W-1:0]  pop_data;
  logic               fifo_full, fifo_empty;
  logic               pop_c;
  logic               baud_done_c;

  assign pop_c       = (state_q == IDLE) && !fifo_empty;
  assign baud_done_c = (baud_q == '0);
  assign in_ready    = !fifo_full;
  assign tx          = tx_q;
  assign busy        = busy_q;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop_c),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register plus baud/shift/line registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= TX_IDLE_LVL;
      busy_q   <= 1'b0;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state: advance when the baud counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!fifo_empty) state_d = START;
      START:  if (baud_done_c) state_d = DATA;
`ifdef RESULT_UART_TX_PARITY_EN
      DATA:   if (baud_done_c && (bit_q == 3'd7)) state_d = PARITY;
      PARITY: if (baud_done_c) state_d = STOP;
`else
      DATA:   if (baud_done_c && (bit_q == 3'd7)) state_d = STOP;
`endif
      STOP:   if (baud_done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output: registered line level follows the state entered on each edge.
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
`ifdef RESULT_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = TX_IDLE_LVL;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          shift_d  = pop_data;
          baud_d   = BAUD_RELOAD;
          bit_d    = 3'd0;
          tx_d     = TX_START_LVL;
          busy_d   = 1'b1;
`ifdef RESULT_UART_TX_PARITY_EN
          parity_d = ^pop_data;
`endif
        end
      end
      START: begin
        if (baud_done_c) begin
          baud_d = BAUD_RELOAD;
          tx_d   = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done_c) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
            tx_d = parity_q;
`else
            tx_d = TX_STOP_LVL;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done_c) begin
          baud_d = BAUD_RELOAD;
          tx_d   = TX_STOP_LVL;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done_c) begin
          baud_d = '0;
          tx_d   = TX_IDLE_LVL;
          busy_d = 1'b0;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        baud_d = '0;
        tx_d   = TX_IDLE_LVL;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at CLK_DIV=4, FIFO_DEPTH=4.
// Expected frame length follows RESULT_UART_TX_PARITY_EN.
module tb_result_uart_tx;

  localparam int unsigned CLK_DIV = 4;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int pass_cnt   = 0;
  int fail_cnt   = 0;
  int total_cnt  = 0;
  int valid_hold = 0;

  result_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid_hold > 0) begin
      valid_hold--;
      if (valid_hold == 0) in_valid = 1'b0;
    end
  endtask

  // Checks {busy,tx} for every cycle of a frame from sample 'skip', then the idle cycle.
  task automatic check_frame(input logic [7:0] b, input int skip);
    logic [FRAME_BITS-1:0] lv;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = b[i];
`ifdef RESULT_UART_TX_PARITY_EN
    lv[9]  = ^b;
    lv[10] = 1'b1;
`else
    lv[9]  = 1'b1;
`endif
    for (int s = skip; s < int'(CLK_DIV * FRAME_BITS); s++) begin
      chk($sformatf("frame_%02h_s%0d", b, s), 32'({busy, tx}),
          32'({1'b1, lv[s / int'(CLK_DIV)]}));
      tick();
    end
    chk($sformatf("frame_%02h_idle", b), 32'({busy, tx}), 32'(2'b01));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'(1));
    chk("post_rst_line", 32'({busy, tx}), 32'(2'b01));

    // Single frame 0xA5
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("a5_count_push", 32'(fifo_count), 32'(1));
    chk("a5_busy_before", 32'(busy), 32'(0));
    tick();
    chk("a5_count_pop", 32'(fifo_count), 32'(0));
    check_frame(8'hA5, 0);

    // Hold in_valid with 0x01..0x06: five accepted, then full
    for (int i = 1; i <= 6; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      chk($sformatf("fill_ready_%0d", i), 32'(in_ready), (i <= 5) ? 32'(1) : 32'(0));
      tick();
      chk($sformatf("fill_count_%0d", i), 32'(fifo_count),
          (i == 1) ? 32'(1) : (i >= 5) ? 32'(4) : 32'(i - 1));
    end
    // 0xFF presented while full, released before space frees up
    in_data    = 8'hFF;
    in_valid   = 1'b1;
    valid_hold = 30;
    check_frame(8'h01, 4);
    chk("full_count_after_f1", 32'(fifo_count), 32'(4));
    for (int b = 2; b <= 5; b++) begin
      tick();
      check_frame(8'(b), 0);
    end
    chk("drain_count", 32'(fifo_count), 32'(0));
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("no_ff_%0d", i), 32'({busy, tx}), 32'(2'b01));
    end

    // Re-present 0xFF once there is room: now it is sent
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_frame(8'hFF, 0);

    // Reset during data bit 3 with two bytes buffered
    in_data  = 8'h34;
    in_valid = 1'b1;
    tick();
    in_data = 8'h81;
    tick();
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("rst_mid_count_before", 32'(fifo_count), 32'(2));
    for (int i = 0; i < 16; i++) tick();
    chk("rst_mid_bit3", 32'({busy, tx}), 32'(2'b10));
    rst_n = 1'b0;
    tick();
    chk("rst_mid_tx", 32'(tx), 32'(1));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_count", 32'(fifo_count), 32'(0));
    chk("rst_mid_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk($sformatf("after_rst_%0d", i), 32'({fifo_count, busy, tx}), 32'(5'b000_01));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
